// File: rtl/im2col_conv_strip.sv
`default_nettype none
// ============================================================================
// Module  : im2col_conv_strip
// Brief   : KxK strided convolution over one BRAM-resident strip, one MAC per
//           cycle, saturated result on a valid/ready stream.
// Revision: 1.0 - initial release
// ============================================================================
module im2col_conv_strip #(
    parameter int DATA_W = 9,
    parameter int K      = 3,
    parameter int IMG_W  = 224,
    parameter int IMG_H  = 28,
    parameter int STRIDE = 1,
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 2,
    parameter int ACC_W  = 24,
    parameter int OUT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              k_wr_en,
    input  logic [7:0]        k_wr_idx,
    input  logic [DATA_W-1:0] k_wr_data,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              start,
    output logic              fmap_rd_en,
    output logic [ADDR_W-1:0] fmap_addr,
    input  logic [DATA_W-1:0] fmap_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int c_NK = K * K;
    localparam int c_OW = (IMG_W - K) / STRIDE + 1;
    localparam int c_OH = (IMG_H - K) / STRIDE + 1;
    localparam int c_NW = $clog2(c_NK + 1);
    localparam int c_DW = $clog2(RD_LAT + 1);
    localparam int c_PW = 2 * DATA_W;

    localparam logic signed [ACC_W-1:0] c_SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0]        c_OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]        c_OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_EMIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]               r_state;
    logic signed [DATA_W-1:0] r_kern [c_NK];
    logic [ADDR_W-1:0]        r_base;
    logic [15:0]              r_row;
    logic [15:0]              r_col;
    logic [2:0]               r_i;
    logic [2:0]               r_j;
    logic [c_NW-1:0]          r_iss;
    logic [c_NW-1:0]          r_n;
    logic [c_DW-1:0]          r_drn;
    logic [RD_LAT-1:0]        r_pipe;
    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_valid;
    logic                     r_last;
    logic                     r_busy;
    logic                     r_done;
    logic [OUT_W-1:0]         r_data;

    logic                     w_issue;
    logic [31:0]              w_offset;
    logic signed [DATA_W-1:0] w_coef;
    logic signed [c_PW-1:0]   w_prod;
    logic signed [ACC_W-1:0]  w_acc_next;
    logic [OUT_W-1:0]         w_sat;
    logic                     w_col_end;
    logic                     w_last_win;

    assign w_issue    = (r_state == S_ISSUE);
    assign w_offset   = (32'(r_row) * 32'(STRIDE) + 32'(r_i)) * 32'(IMG_W)
                      + 32'(r_col) * 32'(STRIDE) + 32'(r_j);
    assign w_col_end  = (r_col == 16'(c_OW - 1));
    assign w_last_win = (r_row == 16'(c_OH - 1)) && w_col_end;

    assign fmap_rd_en = w_issue;
    assign fmap_addr  = w_issue ? r_base + ADDR_W'(w_offset) : '0;
    assign out_valid  = r_valid;
    assign out_data   = r_data;
    assign out_last   = r_last;
    assign busy       = r_busy;
    assign done       = r_done;

    // Returning data arrive in issue order, so the n-th return pairs with kernel[n].
    always_comb begin
        w_coef = '0;
        for (int n = 0; n < c_NK; n++) begin
            if (r_n == c_NW'(n)) w_coef = r_kern[n];
        end
    end

    assign w_prod = c_PW'(w_coef) * c_PW'($signed(fmap_data));

    always_comb begin
        w_acc_next = r_acc;
        if (r_pipe[RD_LAT-1]) w_acc_next = r_acc + ACC_W'(w_prod);
        if (w_acc_next > c_SAT_MAX)      w_sat = c_OUT_MAX;
        else if (w_acc_next < c_SAT_MIN) w_sat = c_OUT_MIN;
        else                             w_sat = OUT_W'(w_acc_next);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_base  <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_iss   <= '0;
            r_n     <= '0;
            r_drn   <= '0;
            r_pipe  <= '0;
            r_acc   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_data  <= '0;
            for (int n = 0; n < c_NK; n++) r_kern[n] <= '0;
        end else begin
            r_done    <= 1'b0;
            r_pipe[0] <= w_issue;
            for (int n = 1; n < RD_LAT; n++) r_pipe[n] <= r_pipe[n-1];
            if (r_pipe[RD_LAT-1]) begin
                r_acc <= w_acc_next;
                r_n   <= r_n + 1'b1;
            end
            if (k_wr_en && !r_busy) begin
                for (int n = 0; n < c_NK; n++) begin
                    if (k_wr_idx == 8'(n)) r_kern[n] <= $signed(k_wr_data);
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base  <= base_addr;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_busy  <= 1'b1;
                        r_iss   <= '0;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_acc   <= '0;
                        r_n     <= '0;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_iss == c_NW'(c_NK - 1)) begin
                        r_drn   <= '0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_iss <= r_iss + 1'b1;
                        if (r_j == 3'(K - 1)) begin
                            r_j <= '0;
                            r_i <= r_i + 1'b1;
                        end else begin
                            r_j <= r_j + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    // The final product lands on this same edge, so latch the bypassed sum.
                    if (r_drn == c_DW'(RD_LAT - 1)) begin
                        r_valid <= 1'b1;
                        r_data  <= w_sat;
                        r_last  <= w_last_win;
                        r_state <= S_EMIT;
                    end else begin
                        r_drn <= r_drn + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        if (w_last_win) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_row   <= '0;
                            r_col   <= '0;
                            r_state <= S_DONE;
                        end else begin
                            r_iss   <= '0;
                            r_i     <= '0;
                            r_j     <= '0;
                            r_acc   <= '0;
                            r_n     <= '0;
                            r_state <= S_ISSUE;
                            if (w_col_end) begin
                                r_col <= '0;
                                r_row <= r_row + 1'b1;
                            end else begin
                                r_col <= r_col + 1'b1;
                            end
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_im2col_conv_strip.sv
`default_nettype none
// ============================================================================
// Module  : tb_im2col_conv_strip
// Brief   : Randomised self-checking bench; two geometries against a direct
//           arithmetic convolution model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_im2col_conv_strip;

    logic        clk = 1'b0;
    logic        reset;
    logic        k_wr_en;
    logic [7:0]  k_wr_idx;
    logic [8:0]  k_wr_data;
    logic [15:0] base_addr;
    logic        start1, start2, out_ready;
    logic        rd1, rd2, v1, v2, l1, l2, b1, b2, dn1, dn2;
    logic [15:0] a1, a2, d1, d2;
    logic [8:0]  fd1, fd2, p1a, p1b, p2a;

    logic signed [8:0] mem [256];
    int          tb_kern [9];
    int          exp_q [$];
    int          n_pass = 0;
    int          n_total = 0;
    logic        sel;
    logic        w_valid, w_last, w_busy, w_done, w_rd;
    logic [15:0] w_data;

    always #5 clk = ~clk;

    im2col_conv_strip #(.DATA_W(9), .K(3), .IMG_W(6), .IMG_H(4), .STRIDE(1),
        .ADDR_W(16), .RD_LAT(2), .ACC_W(24), .OUT_W(16)) dut1 (
        .clk(clk), .reset(reset), .k_wr_en(k_wr_en), .k_wr_idx(k_wr_idx),
        .k_wr_data(k_wr_data), .base_addr(base_addr), .start(start1),
        .fmap_rd_en(rd1), .fmap_addr(a1), .fmap_data(fd1), .out_valid(v1),
        .out_ready(out_ready), .out_data(d1), .out_last(l1), .busy(b1), .done(dn1));

    im2col_conv_strip #(.DATA_W(9), .K(3), .IMG_W(7), .IMG_H(5), .STRIDE(2),
        .ADDR_W(16), .RD_LAT(1), .ACC_W(24), .OUT_W(16)) dut2 (
        .clk(clk), .reset(reset), .k_wr_en(k_wr_en), .k_wr_idx(k_wr_idx),
        .k_wr_data(k_wr_data), .base_addr(base_addr), .start(start2),
        .fmap_rd_en(rd2), .fmap_addr(a2), .fmap_data(fd2), .out_valid(v2),
        .out_ready(out_ready), .out_data(d2), .out_last(l2), .busy(b2), .done(dn2));

    // BRAM models: two-cycle read for dut1, one-cycle for dut2
    always @(posedge clk) begin
        p1a <= mem[a1[7:0]];
        p1b <= p1a;
        p2a <= mem[a2[7:0]];
    end
    assign fd1 = p1b;
    assign fd2 = p2a;

    assign w_valid = sel ? v2  : v1;
    assign w_last  = sel ? l2  : l1;
    assign w_busy  = sel ? b2  : b1;
    assign w_done  = sel ? dn2 : dn1;
    assign w_rd    = sel ? rd2 : rd1;
    assign w_data  = sel ? d2  : d1;

    function automatic int sat16(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    task automatic build_expected(input logic s, input int base);
        int w, h, st, ow, oh;
        longint acc;
        w  = s ? 7 : 6;
        h  = s ? 5 : 4;
        st = s ? 2 : 1;
        ow = (w - 3) / st + 1;
        oh = (h - 3) / st + 1;
        exp_q.delete();
        for (int r = 0; r < oh; r++)
            for (int c = 0; c < ow; c++) begin
                acc = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        acc += longint'(tb_kern[i*3+j]) *
                               longint'(int'(mem[(base + (r*st+i)*w + c*st + j) % 256]));
                exp_q.push_back(sat16(acc));
            end
    endtask

    task automatic write_k(input int idx, input int val);
        @(negedge clk);
        k_wr_en   = 1'b1;
        k_wr_idx  = 8'(idx);
        k_wr_data = 9'(val);
        @(negedge clk);
        k_wr_en = 1'b0;
        if (idx < 9) tb_kern[idx] = val;
    endtask

    task automatic set_kernel_rand(input int lo, input int hi);
        for (int n = 0; n < 9; n++) write_k(n, $urandom_range(hi - lo) + lo);
    endtask

    task automatic fill_rand(input int lo, input int hi);
        for (int a = 0; a < 256; a++) mem[a] = 9'($urandom_range(hi - lo) + lo);
    endtask

    task automatic fill_const(input int v);
        for (int a = 0; a < 256; a++) mem[a] = 9'(v);
    endtask

    // mode 0: always ready, 1: random ready, 2: hold off first result 10 cycles then random
    task automatic run_strip(input logic s, input int base, input int mode, input bit perturb);
        int n, cyc, got, first, last_acc, dones, done_cyc, lat, rd_viol;
        bit hold;
        logic [15:0] held_d, exp_d;
        logic held_l;
        build_expected(s, base);
        n = exp_q.size();
        lat = s ? 1 : 2;
        sel = s;
        @(negedge clk);
        base_addr = 16'(base);
        if (s) start2 = 1'b1; else start1 = 1'b1;
        cyc = 0; got = 0; first = -1; last_acc = -100; dones = 0; done_cyc = -1;
        hold = 1'b0; rd_viol = 0; held_d = '0; held_l = 1'b0;
        while (cyc < 3000 && !(dones > 0 && cyc >= done_cyc + 3)) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start1 = 1'b0; start2 = 1'b0;
                n_total++;
                if (w_busy !== 1'b1) $display("FAIL busy_after_start: got %b want 1", w_busy);
                else n_pass++;
            end
            if (perturb && cyc == 3) begin
                if (s) start2 = 1'b1; else start1 = 1'b1;
                base_addr = 16'(base + 17);
                k_wr_en = 1'b1; k_wr_idx = 8'd4; k_wr_data = 9'(tb_kern[4] + 5);
            end
            if (perturb && cyc == 4) begin
                start1 = 1'b0; start2 = 1'b0; k_wr_en = 1'b0;
            end
            if (w_valid && w_rd) rd_viol++;
            if (w_done) begin
                dones++;
                if (dones == 1) begin
                    done_cyc = cyc;
                    n_total++;
                    if (cyc != last_acc + 1 || got != n || w_busy !== 1'b0)
                        $display("FAIL done_timing: cycle %0d last accept %0d results %0d/%0d busy %b, want cycle %0d busy 0",
                                 cyc, last_acc, got, n, w_busy, last_acc + 1);
                    else n_pass++;
                end
            end
            if (w_valid && first < 0) begin
                first = cyc;
                n_total++;
                if (cyc != 9 + lat + 1) $display("FAIL first_latency: got %0d want %0d", cyc, 9 + lat + 1);
                else n_pass++;
            end
            if (hold) begin
                n_total++;
                if ({w_valid, w_data, w_last} !== {1'b1, held_d, held_l})
                    $display("FAIL hold_stable: valid %b data %0d last %b, want 1 %0d %b",
                             w_valid, $signed(w_data), w_last, $signed(held_d), held_l);
                else n_pass++;
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(2) != 0);
                default: out_ready = (first >= 0 && cyc >= first + 10) ? ($urandom_range(2) != 0) : 1'b0;
            endcase
            if (w_valid && out_ready) begin
                n_total++;
                if (got >= n) begin
                    $display("FAIL extra_result: got result %0d, want only %0d", got + 1, n);
                end else begin
                    exp_d = 16'(exp_q.pop_front());
                    if (w_data !== exp_d || w_last !== (got == n - 1))
                        $display("FAIL result[%0d]: got %0d last %b, want %0d last %b",
                                 got, $signed(w_data), w_last, $signed(exp_d), (got == n - 1));
                    else n_pass++;
                end
                got++;
                last_acc = cyc;
                hold = 1'b0;
            end else if (w_valid) begin
                hold = 1'b1; held_d = w_data; held_l = w_last;
            end else begin
                hold = 1'b0;
            end
        end
        out_ready = 1'b0;
        n_total++;
        if (got != n || dones != 1 || rd_viol != 0)
            $display("FAIL strip_end: results %0d want %0d, done pulses %0d want 1, reads while valid %0d want 0",
                     got, n, dones, rd_viol);
        else n_pass++;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_total++;
        if ({v1, l1, b1, dn1, rd1, a1, d1, v2, l2, b2, dn2, rd2, a2, d2} !== '0)
            $display("FAIL reset_outputs: got %h want 0", {v1, l1, b1, dn1, rd1, a1, d1, v2, l2, b2, dn2, rd2, a2, d2});
        else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        n_total++;
        if ({v1, l1, b1, dn1, rd1, a1, d1, v2, l2, b2, dn2, rd2, a2, d2} !== '0)
            $display("FAIL idle_outputs: got %h want 0", {v1, l1, b1, dn1, rd1, a1, d1, v2, l2, b2, dn2, rd2, a2, d2});
        else n_pass++;
    endtask

    task automatic test_ramp();
        for (int a = 0; a < 256; a++) mem[a] = 9'(a);
        for (int n = 0; n < 9; n++) write_k(n, (n == 4) ? 1 : 0);
        run_strip(1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_all_ones();
        fill_const(127);
        for (int n = 0; n < 9; n++) write_k(n, 1);
        run_strip(1'b0, 0, 1, 1'b0);
    endtask

    task automatic test_saturation();
        fill_const(255);
        for (int n = 0; n < 9; n++) write_k(n, 255);
        run_strip(1'b0, 0, 0, 1'b0);
        for (int n = 0; n < 9; n++) write_k(n, -255);
        run_strip(1'b1, 0, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        fill_rand(-30, 30);
        set_kernel_rand(-20, 20);
        run_strip(1'b0, 7, 2, 1'b0);
        run_strip(1'b1, 11, 2, 1'b0);
    endtask

    task automatic test_stride();
        fill_rand(-256, 255);
        set_kernel_rand(-256, 255);
        run_strip(1'b1, 20, 1, 1'b0);
        fill_rand(-20, 20);
        run_strip(1'b1, 90, 1, 1'b0);
    endtask

    task automatic test_guards();
        fill_rand(-40, 40);
        set_kernel_rand(-30, 30);
        write_k(9, 100);
        write_k(12, -50);
        write_k(255, 33);
        run_strip(1'b0, 10, 1, 1'b1);
        write_k(4, tb_kern[4]);
        run_strip(1'b1, 3, 1, 1'b1);
        write_k(4, tb_kern[4]);
    endtask

    task automatic test_back_to_back();
        fill_rand(-60, 60);
        set_kernel_rand(-60, 60);
        run_strip(1'b0, 0, 0, 1'b0);
        run_strip(1'b0, 40, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        int got, cyc;
        fill_rand(-50, 50);
        set_kernel_rand(-50, 50);
        sel = 1'b0;
        @(negedge clk);
        base_addr = 16'd5;
        start1 = 1'b1;
        out_ready = 1'b1;
        got = 0; cyc = 0;
        while (cyc < 500 && !(got >= 2 && rd1)) begin
            @(negedge clk);
            cyc++;
            start1 = 1'b0;
            if (v1 && out_ready) got++;
        end
        repeat (2) @(negedge clk);
        n_total++;
        if (rd1 !== 1'b1) $display("FAIL midstrip_in_issue: rd_en %b want 1", rd1);
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_total++;
        if ({v1, l1, b1, dn1, rd1, a1, d1} !== '0)
            $display("FAIL midstrip_reset_outputs: got %h want 0", {v1, l1, b1, dn1, rd1, a1, d1});
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b0;
        for (int n = 0; n < 9; n++) tb_kern[n] = 0;
        run_strip(1'b0, 5, 0, 1'b0);
        set_kernel_rand(-50, 50);
        run_strip(1'b0, 5, 1, 1'b0);
    endtask

    initial begin
        reset = 1'b1; k_wr_en = 1'b0; k_wr_idx = '0; k_wr_data = '0; base_addr = '0;
        start1 = 1'b0; start2 = 1'b0; out_ready = 1'b0; sel = 1'b0;
        for (int n = 0; n < 9; n++) tb_kern[n] = 0;
        fill_const(0);
        test_reset();
        test_ramp();
        test_all_ones();
        test_saturation();
        test_backpressure();
        test_stride();
        test_guards();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
